// File: rtl/exp_unpack_ctrl.sv
// exp_unpack_ctrl: unpacks 8-bit exponents from 256-bit packed lines into the
// left or right aligned buffer, one exponent per cycle. It stalls while the
// fetcher has not yet written the packed line that holds the current exponent.
// Optional build macro EXP_UNPACK_ZERO_FILL_EN: after the last real exponent,
// the controller zero-fills the remaining aligned entries up to BRAM_DEPTH-1.
module exp_unpack_ctrl #(
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 256,
    parameter int BRAM_DEPTH = 512
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_target,
    input  logic [9:0]           i_num_groups,
    input  logic [4:0]           i_packed_lines_valid,
    output logic [3:0]           o_exp_packed_rd_addr,
    output logic                 o_exp_packed_rd_target,
    input  logic [MAN_WIDTH-1:0] i_exp_packed_rd_data,
    output logic [8:0]           o_exp_left_wr_addr,
    output logic [8:0]           o_exp_right_wr_addr,
    output logic                 o_exp_left_wr_en,
    output logic                 o_exp_right_wr_en,
    output logic [EXP_WIDTH-1:0] o_exp_left_wr_data,
    output logic [EXP_WIDTH-1:0] o_exp_right_wr_data,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int         LANES = MAN_WIDTH / EXP_WIDTH;
    localparam logic [9:0] DEPTH = 10'(BRAM_DEPTH);
`ifdef EXP_UNPACK_ZERO_FILL_EN
    localparam logic [8:0] LAST_ADDR = 9'(BRAM_DEPTH - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DONE} state_t;

    state_t                 state_q;
    logic [8:0]             k_q;
    logic [9:0]             count_q;
    logic                   target_q;
    logic                   wr_en_l_q, wr_en_r_q;
    logic [8:0]             wr_addr_q;
    logic [EXP_WIDTH-1:0]   wr_data_q;
    logic                   busy_q, done_q;

    logic [EXP_WIDTH-1:0]   lane [LANES];
    logic [9:0]             num_clamped;
    logic                   can_adv, is_last;
    logic [EXP_WIDTH-1:0]   sel_exp;

    // Split the packed line into exponent lanes so the select is a plain index.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane[i] = i_exp_packed_rd_data[i*EXP_WIDTH +: EXP_WIDTH];
    end

    assign num_clamped = (i_num_groups > DEPTH) ? DEPTH : i_num_groups;
    // The line holding exponent k must already be written by the fetcher.
    assign can_adv     = {1'b0, k_q[8:5]} < i_packed_lines_valid;
    assign is_last     = ({1'b0, k_q} == count_q - 10'd1);
    assign sel_exp     = lane[k_q[4:0]];

    assign o_exp_packed_rd_addr   = k_q[8:5];
    assign o_exp_packed_rd_target = target_q;
    assign o_exp_left_wr_addr     = wr_addr_q;
    assign o_exp_right_wr_addr    = wr_addr_q;
    assign o_exp_left_wr_data     = wr_data_q;
    assign o_exp_right_wr_data    = wr_data_q;
    assign o_exp_left_wr_en       = wr_en_l_q;
    assign o_exp_right_wr_en      = wr_en_r_q;
    assign o_busy                 = busy_q;
    assign o_done                 = done_q;

    // Control FSM with registered write port, busy and done outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            count_q   <= '0;
            target_q  <= 1'b0;
            wr_en_l_q <= 1'b0;
            wr_en_r_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_l_q <= 1'b0;
            wr_en_r_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        target_q <= i_target;
                        count_q  <= num_clamped;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (num_clamped == 10'd0) ? S_DONE : S_UNPACK;
                    end
                end
                S_UNPACK: begin
`ifdef EXP_UNPACK_ZERO_FILL_EN
                    if ({1'b0, k_q} >= count_q) begin
                        // Fill phase: independent of fetch progress.
                        wr_en_l_q <= ~target_q;
                        wr_en_r_q <= target_q;
                        wr_addr_q <= k_q;
                        wr_data_q <= '0;
                        if (k_q == LAST_ADDR) state_q <= S_DONE;
                        else                  k_q     <= k_q + 9'd1;
                    end else
`endif
                    if (can_adv) begin
                        wr_en_l_q <= ~target_q;
                        wr_en_r_q <= target_q;
                        wr_addr_q <= k_q;
                        wr_data_q <= sel_exp;
`ifdef EXP_UNPACK_ZERO_FILL_EN
                        if (is_last && k_q == LAST_ADDR) state_q <= S_DONE;
                        else                             k_q     <= k_q + 9'd1;
`else
                        if (is_last) state_q <= S_DONE;
                        else         k_q     <= k_q + 9'd1;
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_unpack_ctrl.sv
// Directed bench for exp_unpack_ctrl: expected writes are queued when a job is
// started and popped by a monitor as the DUT issues aligned-buffer writes.
module tb_exp_unpack_ctrl;

    logic         i_clk = 1'b0;
    logic         i_reset, i_start, i_target;
    logic [9:0]   i_num_groups;
    logic [4:0]   i_packed_lines_valid;
    logic [3:0]   o_exp_packed_rd_addr;
    logic         o_exp_packed_rd_target;
    logic [255:0] i_exp_packed_rd_data;
    logic [8:0]   o_exp_left_wr_addr, o_exp_right_wr_addr;
    logic         o_exp_left_wr_en, o_exp_right_wr_en;
    logic [7:0]   o_exp_left_wr_data, o_exp_right_wr_data;
    logic         o_busy, o_done;

    exp_unpack_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_target(i_target),
        .i_num_groups(i_num_groups), .i_packed_lines_valid(i_packed_lines_valid),
        .o_exp_packed_rd_addr(o_exp_packed_rd_addr),
        .o_exp_packed_rd_target(o_exp_packed_rd_target),
        .i_exp_packed_rd_data(i_exp_packed_rd_data),
        .o_exp_left_wr_addr(o_exp_left_wr_addr), .o_exp_right_wr_addr(o_exp_right_wr_addr),
        .o_exp_left_wr_en(o_exp_left_wr_en), .o_exp_right_wr_en(o_exp_right_wr_en),
        .o_exp_left_wr_data(o_exp_left_wr_data), .o_exp_right_wr_data(o_exp_right_wr_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       side;
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t          sb[$];
    logic [255:0] mem [16];
    int           errors = 0, checks = 0;
    int           cyc = 0, wr_cnt = 0, done_cnt = 0;
    int           last_wr_cyc = 0, done_cyc = 0, start_cyc = 0, wr_base = 0;
    wr_t          mon_obs, mon_exp;

    assign i_exp_packed_rd_data = mem[o_exp_packed_rd_addr];

    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every aligned write must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (o_exp_left_wr_en || o_exp_right_wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            chk("one_side", 32'(o_exp_left_wr_en & o_exp_right_wr_en), 32'd0);
            mon_obs.side = o_exp_right_wr_en;
            mon_obs.addr = o_exp_right_wr_en ? o_exp_right_wr_addr : o_exp_left_wr_addr;
            mon_obs.data = o_exp_right_wr_en ? o_exp_right_wr_data : o_exp_left_wr_data;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_wr: got %0h expected no write", mon_obs);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("wr_side_addr_data", 32'(mon_obs), 32'(mon_exp));
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [7:0] exp_byte(input int k, input int mode);
        logic [7:0] v;
        v = 8'(k);
        return (mode != 0) ? (v ^ 8'h5A) : v;
    endfunction

    task automatic fill_mem(input int mode);
        for (int l = 0; l < 16; l++)
            for (int b = 0; b < 32; b++)
                mem[l][8*b +: 8] = exp_byte(l*32 + b, mode);
    endtask

    task automatic start_job(input logic tgt, input int n, input int mode, input int lines);
        int cnt;
        cnt = (n > 512) ? 512 : n;
        fill_mem(mode);
        i_packed_lines_valid = 5'(lines);
        for (int k = 0; k < cnt; k++) sb.push_back({tgt, 9'(k), exp_byte(k, mode)});
`ifdef EXP_UNPACK_ZERO_FILL_EN
        if (cnt > 0)
            for (int k = cnt; k < 512; k++) sb.push_back({tgt, 9'(k), 8'h00});
`endif
        @(negedge i_clk);
        i_start = 1'b1; i_target = tgt; i_num_groups = 10'(n);
        @(negedge i_clk);
        start_cyc = cyc;
        wr_base   = wr_cnt;
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int  d0;
        logic got;
        d0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk); #1;
            if (done_cnt != d0) begin got = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int d0, w0;
        logic hit;
        i_reset = 1'b1; i_start = 1'b0; i_target = 1'b0;
        i_num_groups = '0; i_packed_lines_valid = '0;
        fill_mem(0);
        #1;
        chk("rst_wr_en", 32'({o_exp_left_wr_en, o_exp_right_wr_en}), 32'd0);
        chk("rst_wr_addr_data", 32'({o_exp_left_wr_addr, o_exp_left_wr_data}), 32'd0);
        chk("rst_rd", 32'({o_exp_packed_rd_addr, o_exp_packed_rd_target}), 32'd0);
        chk("rst_busy_done", 32'({o_busy, o_done}), 32'd0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;

        // 64 left writes, data equals address, no stalls.
        start_job(1'b0, 64, 0, 16);
        #1 chk("t1_busy", 32'(o_busy), 32'd1);
        wait_done(100, "t1");
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk("t1_throughput", 32'(done_cyc - start_cyc), 32'd65);
        chk("t1_busy_idle", 32'(o_busy), 32'd0);
        @(negedge i_clk); #1 chk("t1_done_one_cycle", 32'(o_done), 32'd0);

        // Zero-length job: done only, no writes.
        start_job(1'b1, 0, 0, 16);
        wait_done(10, "t0");
        chk("t0_done_cycle", 32'(done_cyc - start_cyc), 32'd1);
        chk("t0_no_writes", 32'(wr_cnt - wr_base), 32'd0);

        // Right side, stall on line 1, ignored restart during stall.
        start_job(1'b1, 40, 1, 1);
        repeat (50) @(negedge i_clk);
        #1;
        chk("t2_stall_count", 32'(wr_cnt - wr_base), 32'd32);
        chk("t2_stall_rd_addr", 32'(o_exp_packed_rd_addr), 32'd1);
        chk("t2_stall_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        i_start = 1'b1; i_target = 1'b0; i_num_groups = 10'd5;
        @(negedge i_clk);
        i_start = 1'b0;
        #1;
        chk("t2_target_kept", 32'(o_exp_packed_rd_target), 32'd1);
        chk("t2_no_restart", 32'(wr_cnt - wr_base), 32'd32);
        i_packed_lines_valid = 5'd2;
        wait_done(50, "t2");
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));

        // Over-range count clamps to 512 entries.
        start_job(1'b1, 600, 1, 16);
        wait_done(700, "clamp");
        chk("clamp_sb_empty", 32'(sb.size()), 32'd0);
        chk("clamp_writes", 32'(wr_cnt - wr_base), 32'd512);
        chk("clamp_throughput", 32'(done_cyc - start_cyc), 32'd513);

        // Reset while writing address 100 of a 512-entry job.
        start_job(1'b0, 512, 0, 16);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk); #1;
            if (wr_cnt - wr_base >= 101) begin hit = 1'b1; break; end
        end
        chk("rst_mid_reached", 32'(hit), 32'd1);
        chk("rst_mid_addr_before", 32'(o_exp_left_wr_addr), 32'd100);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_wr_en", 32'({o_exp_left_wr_en, o_exp_right_wr_en}), 32'd0);
        chk("rst_mid_addr_data", 32'({o_exp_left_wr_addr, o_exp_left_wr_data}), 32'd0);
        chk("rst_mid_busy_done", 32'({o_busy, o_done}), 32'd0);
        sb.delete();
        d0 = done_cnt;
        w0 = wr_cnt;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        #1;
        chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        chk("rst_mid_no_writes", 32'(wr_cnt), 32'(w0));
        start_job(1'b1, 8, 1, 16);
        wait_done(30, "after_rst");
        chk("after_rst_sb_empty", 32'(sb.size()), 32'd0);
        chk("after_rst_writes", 32'(wr_cnt - wr_base), 32'd8);
        chk("after_rst_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));

`ifdef EXP_UNPACK_ZERO_FILL_EN
        // Zero fill of addresses 500..511 after the real exponents.
        start_job(1'b0, 500, 0, 16);
        wait_done(700, "fill");
        chk("fill_sb_empty", 32'(sb.size()), 32'd0);
        chk("fill_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk("fill_throughput", 32'(done_cyc - start_cyc), 32'd513);
`endif

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
